// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl
// Streaming FIFO that keeps its storage in one single-port SRAM macro.
// Words arrive on a valid/ready input stream and are written into an SRAM
// ring. Words are read back in order into a 2-entry output buffer, which
// hides the macro's one-cycle read latency from the output stream.
// Reads and writes share the single port. When both want it in the same
// cycle, the port goes to the side named by prio, and prio then flips.

module sram_fifo_ctrl #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [ADDR_W+1:0] count,
  output logic [ADDR_W-1:0] sram_a,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb,
  output logic [WIDTH-1:0]  sram_i,
  input  logic [WIDTH-1:0]  sram_o
);

  // Which side wins the SRAM port when reads and writes collide.
  typedef enum logic {
    PRIO_READ  = 1'b0,
    PRIO_WRITE = 1'b1
  } prio_t;

  localparam logic [ADDR_W:0] MEM_FULL   = (ADDR_W+1)'(DEPTH);
  localparam int              OBUF_DEPTH = 2;

  // Ring pointers. DEPTH is a power of two, so they wrap by plain overflow.
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_next;

  // Words resident in the SRAM and not yet read out (0..DEPTH).
  logic [ADDR_W:0]   mem_cnt_reg;
  logic [ADDR_W:0]   mem_cnt_next;

  // A read was issued last cycle, so its data is on sram_o this cycle.
  logic              rd_inflight_reg;
  logic              rd_inflight_next;

  // Output buffer. Slot 0 is always the head of the queue.
  logic [WIDTH-1:0]  obuf_reg  [OBUF_DEPTH];
  logic [WIDTH-1:0]  obuf_next [OBUF_DEPTH];
  logic [1:0]        obuf_cnt_reg;
  logic [1:0]        obuf_cnt_next;

  // Registered total occupancy: SRAM + in-flight read + output buffer.
  logic [ADDR_W+1:0] count_reg;
  logic [ADDR_W+1:0] count_next;

  prio_t             prio_reg;
  prio_t             prio_next;

  // While idle, the SRAM pins keep the values of the last access.
  logic [ADDR_W-1:0] a_hold_reg;
  logic              web_hold_reg;
  logic [WIDTH-1:0]  i_hold_reg;

  // Per-cycle request and grant terms.
  logic              rd_want;
  logic              wr_can;
  logic              both_req;
  logic              wr_grant;
  logic              rd_grant;
  logic              obuf_push;
  logic              obuf_pop;

  // Port requests and grants.
  // A read is only requested when the buffer is sure to have room for its
  // data, counting a read that is already in flight. Nothing is granted
  // while rst is high, so the macro is never touched during reset.
  always_comb begin
    rd_want  = 1'b0;
    wr_can   = 1'b0;
    both_req = 1'b0;
    in_ready = 1'b0;
    wr_grant = 1'b0;
    rd_grant = 1'b0;

    rd_want  = (mem_cnt_reg != '0) &&
               (({1'b0, obuf_cnt_reg} + {2'b00, rd_inflight_reg}) < 3'd2);
    wr_can   = (mem_cnt_reg != MEM_FULL);
    both_req = rd_want && in_valid && wr_can;

    in_ready = wr_can && !(rd_want && (prio_reg == PRIO_READ)) && !rst;
    wr_grant = in_valid && in_ready;
    rd_grant = rd_want && !wr_grant && !rst;
  end

  // Arbitration priority: next state.
  // Priority flips only after a cycle in which both sides asked for the
  // port. A grant is always made in such a cycle.
  always_comb begin
    prio_next = prio_reg;
    if (both_req && !rst) begin
      prio_next = (prio_reg == PRIO_READ) ? PRIO_WRITE : PRIO_READ;
    end
  end

  // Arbitration priority: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_reg <= PRIO_READ;
    end else begin
      prio_reg <= prio_next;
    end
  end

  // SRAM pin drive.
  // A granted access drives the pins in the same cycle. The macro samples
  // them on the closing edge.
  always_comb begin
    sram_csb = 1'b1;
    sram_web = web_hold_reg;
    sram_a   = a_hold_reg;
    sram_i   = i_hold_reg;
    sram_oeb = 1'b0;

    if (wr_grant) begin
      sram_csb = 1'b0;
      sram_web = 1'b0;
      sram_a   = wr_ptr_reg;
      sram_i   = in_data;
    end else if (rd_grant) begin
      sram_csb = 1'b0;
      sram_web = 1'b1;
      sram_a   = rd_ptr_reg;
    end
  end

  // Capture the pin values so that idle cycles keep them stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_hold_reg   <= '0;
      web_hold_reg <= 1'b1;
      i_hold_reg   <= '0;
    end else begin
      a_hold_reg   <= sram_a;
      web_hold_reg <= sram_web;
      i_hold_reg   <= sram_i;
    end
  end

  // Pointer, SRAM occupancy and in-flight tracking: next state.
  // A read and a write never happen in the same cycle, so mem_cnt moves by
  // at most one.
  always_comb begin
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    mem_cnt_next     = mem_cnt_reg;
    rd_inflight_next = rd_grant;

    if (wr_grant) begin
      wr_ptr_next  = wr_ptr_reg + ADDR_W'(1);
      mem_cnt_next = mem_cnt_reg + (ADDR_W+1)'(1);
    end else if (rd_grant) begin
      rd_ptr_next  = rd_ptr_reg + ADDR_W'(1);
      mem_cnt_next = mem_cnt_reg - (ADDR_W+1)'(1);
    end
  end

  // Output buffer: next state.
  // Read data always goes behind any word already buffered, so it can never
  // overtake one. rd_want ensures the buffer holds at most one word when
  // data returns. A pop shifts slot 1 forward into slot 0.
  always_comb begin
    obuf_push     = rd_inflight_reg;
    obuf_pop      = out_valid && out_ready;
    obuf_next     = obuf_reg;
    obuf_cnt_next = obuf_cnt_reg;

    case ({obuf_push, obuf_pop})
      2'b10: begin
        obuf_next[obuf_cnt_reg[0]] = sram_o;
        obuf_cnt_next              = obuf_cnt_reg + 2'd1;
      end
      2'b01: begin
        obuf_next[0]  = obuf_reg[1];
        obuf_cnt_next = obuf_cnt_reg - 2'd1;
      end
      2'b11: begin
        if (obuf_cnt_reg == 2'd1) begin
          obuf_next[0] = sram_o;
        end else begin
          obuf_next[0] = obuf_reg[1];
          obuf_next[1] = sram_o;
        end
      end
      default: begin
      end
    endcase
  end

  // Occupancy as it will stand after this edge, so count stays registered.
  always_comb begin
    count_next = (ADDR_W+2)'(mem_cnt_next) +
                 (ADDR_W+2)'(obuf_cnt_next) +
                 (ADDR_W+2)'(rd_inflight_next);
  end

  // Control state registers.
  // Reset discards any in-flight read and drops all buffered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      mem_cnt_reg     <= '0;
      rd_inflight_reg <= 1'b0;
      obuf_cnt_reg    <= '0;
      count_reg       <= '0;
    end else begin
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      mem_cnt_reg     <= mem_cnt_next;
      rd_inflight_reg <= rd_inflight_next;
      obuf_cnt_reg    <= obuf_cnt_next;
      count_reg       <= count_next;
    end
  end

  // Output buffer data. Validity comes from obuf_cnt, so the data needs no reset.
  always_ff @(posedge clk) begin
    obuf_reg <= obuf_next;
  end

  assign out_valid = (obuf_cnt_reg != 2'd0);
  assign out_data  = obuf_reg[0];
  assign count     = count_reg;

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl
// Directed bench for sram_fifo_ctrl with a behavioural model of the SRAM
// macro. A cycle table covers reset, single-word latency and a first
// collision. Hand-written sequences cover fill to full, drain, wrap,
// sustained contention and reset in mid-stream.

module tb_sram_fifo_ctrl;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [ADDR_W+1:0] count;
  logic [ADDR_W-1:0] sram_a;
  logic              sram_csb;
  logic              sram_web;
  logic              sram_oeb;
  logic [WIDTH-1:0]  sram_i;
  logic [WIDTH-1:0]  sram_o;

  always #5 clk = ~clk;

  sram_fifo_ctrl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count),
    .sram_a   (sram_a),
    .sram_csb (sram_csb),
    .sram_web (sram_web),
    .sram_oeb (sram_oeb),
    .sram_i   (sram_i),
    .sram_o   (sram_o)
  );

  // SRAM macro model: synchronous single port, read data valid next cycle.
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) mem[sram_a] <= sram_i;
      else           sram_o      <= mem[sram_a];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard and per-cycle observations, updated by step().
  logic [WIDTH-1:0]  sb [$];
  int                n_in  = 0;
  int                n_out = 0;
  logic              acc;
  logic              popped;
  logic [1:0]        grant_kind;   // 0 idle, 1 write, 2 read
  logic [ADDR_W-1:0] last_wr_a;
  logic [WIDTH-1:0]  last_out;

  // Called at posedge+1 with inputs set. Observes the cycle at the negedge,
  // then returns at the next posedge+1.
  task automatic step();
    logic [WIDTH-1:0] exp_w;
    @(negedge clk);
    acc        = in_valid && in_ready;
    popped     = out_valid && out_ready;
    grant_kind = sram_csb ? 2'd0 : (sram_web ? 2'd2 : 2'd1);
    if (!sram_csb && !sram_web) last_wr_a = sram_a;
    if (acc) begin
      sb.push_back(in_data);
      n_in++;
    end
    if (popped) begin
      last_out = out_data;
      n_out++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_empty: got 0x%0h, expected no word", out_data);
      end else begin
        exp_w = sb.pop_front();
        check("pop_data", out_data, exp_w);
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic              iv;
    logic [WIDTH-1:0]  id;
    logic              ordy;
    logic              e_rdy;
    logic              e_ov;
    logic [WIDTH-1:0]  e_od;
    logic [ADDR_W+1:0] e_cnt;
    logic              e_csb;
    logic              e_web;
    logic [ADDR_W-1:0] e_a;
    logic [WIDTH-1:0]  e_i;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic iv, input logic [31:0] id, input logic ordy,
                              input logic e_rdy, input logic e_ov, input logic [31:0] e_od,
                              input int e_cnt, input logic e_csb, input logic e_web,
                              input int e_a, input logic [31:0] e_i);
    vec_t v;
    v.iv    = iv;
    v.id    = id;
    v.ordy  = ordy;
    v.e_rdy = e_rdy;
    v.e_ov  = e_ov;
    v.e_od  = e_od;
    v.e_cnt = (ADDR_W+2)'(e_cnt);
    v.e_csb = e_csb;
    v.e_web = e_web;
    v.e_a   = ADDR_W'(e_a);
    v.e_i   = e_i;
    return v;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_in;
    int base_out;
    int writes;
    int reads;
    int viol;
    int steps;
    logic [1:0]       prev;
    logic [WIDTH-1:0] wdata;

    // One row per cycle after reset release.
    //               iv id            ordy rdy ov od            cnt csb web a  i
    vecs[0]  = mk(0, 32'h0,        0,   1,  0, 32'h0,        0,  1,  0,  0, 32'h0);
    vecs[1]  = mk(1, 32'hDEADBEEF, 0,   1,  0, 32'h0,        0,  0,  0,  0, 32'hDEADBEEF);
    vecs[2]  = mk(0, 32'h0,        0,   0,  0, 32'h0,        1,  0,  1,  0, 32'h0);
    vecs[3]  = mk(0, 32'h0,        0,   1,  0, 32'h0,        1,  1,  0,  0, 32'h0);
    vecs[4]  = mk(0, 32'h0,        0,   1,  1, 32'hDEADBEEF, 1,  1,  0,  0, 32'h0);
    vecs[5]  = mk(0, 32'h0,        1,   1,  1, 32'hDEADBEEF, 1,  1,  0,  0, 32'h0);
    vecs[6]  = mk(0, 32'h0,        0,   1,  0, 32'h0,        0,  1,  0,  0, 32'h0);
    vecs[7]  = mk(1, 32'h11,       1,   1,  0, 32'h0,        0,  0,  0,  1, 32'h11);
    vecs[8]  = mk(1, 32'h22,       1,   0,  0, 32'h0,        1,  0,  1,  1, 32'h0);
    vecs[9]  = mk(1, 32'h22,       1,   1,  0, 32'h0,        1,  0,  0,  2, 32'h22);
    vecs[10] = mk(0, 32'h0,        1,   1,  1, 32'h11,       2,  0,  1,  2, 32'h0);
    vecs[11] = mk(0, 32'h0,        1,   1,  0, 32'h0,        1,  1,  0,  0, 32'h0);
    vecs[12] = mk(0, 32'h0,        1,   1,  1, 32'h22,       1,  1,  0,  0, 32'h0);
    vecs[13] = mk(0, 32'h0,        0,   1,  0, 32'h0,        0,  1,  0,  0, 32'h0);

    // Reset held for two cycles.
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    last_wr_a = '1;
    last_out  = '0;
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_csb", sram_csb, 1);
    check("rst_oeb", sram_oeb, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Cycle table.
    for (int i = 0; i < NVEC; i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].id;
      out_ready = vecs[i].ordy;
      @(negedge clk);
      $display("vec %0d: in_ready=%0d out_valid=%0d out_data=0x%08h count=%0d csb=%0d web=%0d a=%0d",
               i, in_ready, out_valid, out_data, count, sram_csb, sram_web, sram_a);
      check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_rdy);
      check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
      if (vecs[i].e_ov) check($sformatf("v%0d_out_data", i), out_data, vecs[i].e_od);
      check($sformatf("v%0d_count", i), count, vecs[i].e_cnt);
      check($sformatf("v%0d_csb", i), sram_csb, vecs[i].e_csb);
      if (!vecs[i].e_csb) begin
        check($sformatf("v%0d_web", i), sram_web, vecs[i].e_web);
        check($sformatf("v%0d_a", i), sram_a, vecs[i].e_a);
        if (!vecs[i].e_web) check($sformatf("v%0d_i", i), sram_i, vecs[i].e_i);
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Fill to full with the output stalled: 512 in SRAM + 2 buffered.
    base_in  = n_in;
    in_valid = 1'b1;
    for (int k = 0; k < 700; k++) begin
      in_data = WIDTH'(n_in - base_in);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    $display("fill: accepted=%0d in_ready=%0d count=%0d", n_in - base_in, in_ready, count);
    check("fill_accepted", n_in - base_in, 514);
    check("fill_in_ready", in_ready, 0);
    check("fill_count", count, 514);
    check("fill_out_valid", out_valid, 1);
    check("fill_head", out_data, 0);
    @(posedge clk);
    #1;

    // Drain: words 0..513 in order (checked against the scoreboard).
    base_out  = n_out;
    out_ready = 1'b1;
    for (int k = 0; k < 3000 && (n_out - base_out) < 514; k++) step();
    out_ready = 1'b0;
    @(negedge clk);
    $display("drain: emitted=%0d count=%0d", n_out - base_out, count);
    check("drain_emitted", n_out - base_out, 514);
    check("drain_count", count, 0);
    check("drain_out_valid", out_valid, 0);
    @(posedge clk);
    #1;

    // Random valid/ready streaming across pointer wrap.
    base_in  = n_in;
    base_out = n_out;
    wdata    = $urandom;
    for (int k = 0; k < 20000 && (n_out - base_out) < 1500; k++) begin
      in_valid  = ((n_in - base_in) < 1500) && ($urandom_range(0, 99) < 60);
      in_data   = wdata;
      out_ready = ($urandom_range(0, 99) < 60);
      step();
      if (acc) wdata = $urandom;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    $display("wrap: in=%0d out=%0d count=%0d", n_in - base_in, n_out - base_out, count);
    check("wrap_in", n_in - base_in, 1500);
    check("wrap_out", n_out - base_out, 1500);
    check("wrap_count", count, 0);
    @(posedge clk);
    #1;

    // Contention: half-full SRAM, both streams active continuously.
    base_in  = n_in;
    in_valid = 1'b1;
    for (int k = 0; k < 1000 && (n_in - base_in) < 256; k++) begin
      in_data = 32'h5000_0000 + WIDTH'(n_in);
      step();
    end
    out_ready = 1'b1;
    writes    = 0;
    reads     = 0;
    viol      = 0;
    prev      = 2'd0;
    for (int k = 0; k < 40; k++) begin
      in_data = 32'h5000_0000 + WIDTH'(n_in);
      step();
      if (k >= 6) begin
        if (grant_kind == 2'd1) writes++;
        if (grant_kind == 2'd2) reads++;
        if (grant_kind == 2'd0 || grant_kind == prev) viol++;
      end
      prev = grant_kind;
    end
    $display("contention: writes=%0d reads=%0d repeats=%0d", writes, reads, viol);
    check("cont_alternation", viol, 0);
    check("cont_writes", writes, 17);
    check("cont_reads", reads, 17);
    in_valid = 1'b0;
    for (int k = 0; k < 2000 && sb.size() > 0; k++) step();
    out_ready = 1'b0;
    @(negedge clk);
    check("cont_left", sb.size(), 0);
    check("cont_count", count, 0);
    @(posedge clk);
    #1;

    // Reset mid-stream: 10 words queued and a read in flight.
    base_in  = n_in;
    in_valid = 1'b1;
    for (int k = 0; k < 100 && (n_in - base_in) < 10; k++) begin
      in_data = 32'h100 + WIDTH'(n_in - base_in);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    grant_kind = 2'd0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (grant_kind == 2'd2) break;
    end
    check("mid_read_issued", grant_kind, 2);
    rst       = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    check("mid_rst_csb", sram_csb, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    $display("mid reset: count=%0d out_valid=%0d in_ready=%0d", count, out_valid, in_ready);
    check("mid_count", count, 0);
    check("mid_out_valid", out_valid, 0);
    check("mid_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    last_wr_a = '1;
    in_valid  = 1'b1;
    in_data   = 32'h1;
    step();
    check("mid_accept", acc, 1);
    check("mid_wr_addr", last_wr_a, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    base_out  = n_out;
    steps     = 0;
    for (int k = 0; k < 20 && n_out == base_out; k++) begin
      step();
      steps++;
    end
    $display("mid reset: first word 0x%08h after %0d cycles", last_out, steps);
    check("mid_first_word", last_out, 32'h1);
    check("mid_latency", steps, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
